// File: rtl/morse_decoder.sv
// Serial International Morse receiver: classifies unit-timed mark/space runs
// into dots and dashes and decodes each character to ASCII on a valid/ready register.
module morse_decoder (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       bit_en,
    input  logic       key_in,
    output logic [7:0] ascii_out,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       err,
    output logic       ovf
);

    typedef enum logic [1:0] {IDLE, MARK, GAP, WORD} state_t;

    state_t     state;
    logic [2:0] mark_cnt;
    logic [2:0] gap_cnt;
    logic [2:0] len;
    logic [4:0] pat;
    logic       bad;

    logic [7:0] dec_char;
    logic       can_load;
    logic       elem_ok;

    // Keyed on {len, pat}; pat holds the first element in its highest used bit, 1 = dash.
    function automatic logic [7:0] decode(input logic [2:0] n, input logic [4:0] p);
        case ({n, p})
            {3'd2, 5'b00001}: decode = 8'h41; // A
            {3'd4, 5'b01000}: decode = 8'h42; // B
            {3'd4, 5'b01010}: decode = 8'h43; // C
            {3'd3, 5'b00100}: decode = 8'h44; // D
            {3'd1, 5'b00000}: decode = 8'h45; // E
            {3'd4, 5'b00010}: decode = 8'h46; // F
            {3'd3, 5'b00110}: decode = 8'h47; // G
            {3'd4, 5'b00000}: decode = 8'h48; // H
            {3'd2, 5'b00000}: decode = 8'h49; // I
            {3'd4, 5'b00111}: decode = 8'h4A; // J
            {3'd3, 5'b00101}: decode = 8'h4B; // K
            {3'd4, 5'b00100}: decode = 8'h4C; // L
            {3'd2, 5'b00011}: decode = 8'h4D; // M
            {3'd2, 5'b00010}: decode = 8'h4E; // N
            {3'd3, 5'b00111}: decode = 8'h4F; // O
            {3'd4, 5'b00110}: decode = 8'h50; // P
            {3'd4, 5'b01101}: decode = 8'h51; // Q
            {3'd3, 5'b00010}: decode = 8'h52; // R
            {3'd3, 5'b00000}: decode = 8'h53; // S
            {3'd1, 5'b00001}: decode = 8'h54; // T
            {3'd3, 5'b00001}: decode = 8'h55; // U
            {3'd4, 5'b00001}: decode = 8'h56; // V
            {3'd3, 5'b00011}: decode = 8'h57; // W
            {3'd4, 5'b01001}: decode = 8'h58; // X
            {3'd4, 5'b01011}: decode = 8'h59; // Y
            {3'd4, 5'b01100}: decode = 8'h5A; // Z
            {3'd5, 5'b11111}: decode = 8'h30;
            {3'd5, 5'b01111}: decode = 8'h31;
            {3'd5, 5'b00111}: decode = 8'h32;
            {3'd5, 5'b00011}: decode = 8'h33;
            {3'd5, 5'b00001}: decode = 8'h34;
            {3'd5, 5'b00000}: decode = 8'h35;
            {3'd5, 5'b10000}: decode = 8'h36;
            {3'd5, 5'b11000}: decode = 8'h37;
            {3'd5, 5'b11100}: decode = 8'h38;
            {3'd5, 5'b11110}: decode = 8'h39;
            default:          decode = 8'h00;
        endcase
    endfunction

    assign dec_char = decode(len, pat);
    assign can_load = !out_valid || out_ready;
    assign elem_ok  = (mark_cnt == 3'd1) || (mark_cnt == 3'd3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            mark_cnt  <= 3'd0;
            gap_cnt   <= 3'd0;
            len       <= 3'd0;
            pat       <= 5'd0;
            bad       <= 1'b0;
            ascii_out <= 8'h00;
            out_valid <= 1'b0;
            err       <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            err <= 1'b0;
            ovf <= 1'b0;
            // A load later in this block overrides the handshake clear.
            if (out_valid && out_ready)
                out_valid <= 1'b0;
            if (bit_en) begin
                case (state)
                    IDLE: begin
                        if (key_in) begin
                            len      <= 3'd0;
                            pat      <= 5'd0;
                            bad      <= 1'b0;
                            mark_cnt <= 3'd1;
                            state    <= MARK;
                        end
                    end
                    MARK: begin
                        if (key_in) begin
                            if (mark_cnt != 3'd7)
                                mark_cnt <= mark_cnt + 3'd1;
                        end else begin
                            if (len == 3'd5 || !elem_ok) begin
                                bad <= 1'b1;
                            end else begin
                                pat <= {pat[3:0], (mark_cnt == 3'd3)};
                                len <= len + 3'd1;
                            end
                            gap_cnt <= 3'd1;
                            state   <= GAP;
                        end
                    end
                    GAP: begin
                        if (key_in) begin
                            mark_cnt <= 3'd1;
                            state    <= MARK;
                        end else begin
                            gap_cnt <= gap_cnt + 3'd1;
                            if (gap_cnt == 3'd2) begin
                                state <= WORD;
                                if (bad || dec_char == 8'h00) begin
                                    err <= 1'b1;
                                end else if (can_load) begin
                                    ascii_out <= dec_char;
                                    out_valid <= 1'b1;
                                end else begin
                                    ovf <= 1'b1;
                                end
                            end
                        end
                    end
                    WORD: begin
                        if (key_in) begin
                            len      <= 3'd0;
                            pat      <= 5'd0;
                            bad      <= 1'b0;
                            mark_cnt <= 3'd1;
                            state    <= MARK;
                        end else begin
                            gap_cnt <= gap_cnt + 3'd1;
                            if (gap_cnt == 3'd6) begin
                                state <= IDLE;
                                if (can_load) begin
                                    ascii_out <= 8'h20;
                                    out_valid <= 1'b1;
                                end else begin
                                    ovf <= 1'b1;
                                end
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/morse_decoder.md
# morse_decoder

Serial Morse receiver: the inverse of the ASCII-to-Morse translator. It samples a keyed on/off stream, one bit per Morse time unit, and classifies mark runs as dots or dashes. It measures gaps to find character and word boundaries, decodes standard International Morse (A–Z, 0–9) to uppercase ASCII, and presents each character on a one-entry valid/ready output register. It sits at the receive end of the Morse link, downstream of whatever debounces and unit-times the key line.

## Interface
- No parameters. Unit timing is supplied externally via `bit_en`.

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `bit_en`  in  1  one-cycle strobe; marks one Morse time unit; `key_in` is sampled only when high.
- `key_in`  in  1  keyed line: 1 = mark (tone on), 0 = space.
- `ascii_out`  out  8  decoded character; `0x20` for a word gap.
- `out_valid`  out  1  `ascii_out` holds an unconsumed character.
- `out_ready`  in  1  consumer accepts when `out_valid && out_ready`.
- `err`  out  1  one-cycle pulse: the character was malformed or unknown.
- `ovf`  out  1  one-cycle pulse: a decoded character was dropped because the output was full.

## Operation
- Element rules, counted in units (strobes):
  - mark run of 1 = dot; mark run of 3 = dash; run of 2 or ≥4 = bad (mark counter saturates at 7).
  - gap of 1–2 = intra-character; gap reaching 3 = character end; gap reaching 7 = word end.
- Symbol accumulator: 3-bit `len` and 5-bit `pat`. Each element shifts left into `pat[0]` (1 = dash); `len` increments. A 6th element sets the char-bad flag; `len` and `pat` then stop updating.
- FSM, advancing only on `bit_en`:
  - IDLE: key=0 stays. key=1 clears `len`, `pat` and bad; sets mark_cnt=1; goes to MARK.
  - MARK: key=1 increments mark_cnt. key=0 classifies and appends the element, sets gap_cnt=1, goes to GAP.
  - GAP: key=1 sets mark_cnt=1 and goes to MARK (same character). key=0 increments gap_cnt; at 3, decode and go to WORD.
  - WORD: key=0 increments gap_cnt; at 7, emit `0x20` and go to IDLE. key=1 starts a new character (clear accumulator, mark_cnt=1, MARK) with no space emitted.
- Decode uses standard Morse: A=.- … Z=--.., 0=-----, 1=.----, …, 9=----. and is keyed on (`len`, `pat[len-1:0]`).
  - If bad is set or the code is absent from the table: pulse `err`; nothing is loaded.
- Output register load, for a valid character or space:
  - If `!out_valid`, or `out_valid && out_ready` in the same cycle: load `ascii_out`, set `out_valid`.
  - Otherwise keep the old contents and pulse `ovf`.
- `out_valid` clears on `out_valid && out_ready` when no load occurs that cycle.
- Leading zeros in IDLE are ignored. A space is emitted only after at least one character attempt (WORD is reachable only via GAP).

## Timing
- Reset values: `ascii_out`=0x00, `out_valid`=0, `err`=0, `ovf`=0, FSM=IDLE, all counters and accumulator 0.
- Reset is async and may occur mid-character: the partial symbol is discarded and any held output is lost.
- Latency: `out_valid`, `err` or `ovf` asserts in the cycle after the `bit_en` cycle that delivers the 3rd (or 7th) gap unit.
- `err` and `ovf` are single-cycle pulses, registered, and never asserted together.
- When `bit_en`=0, FSM and counters are frozen. The output handshake still operates every cycle.
- `out_ready` is ignored while `out_valid`=0.

## Test plan
- "E": strobes with key 1,0,0,0, `out_ready`=1 → `ascii_out`=0x45 and `out_valid`=1 the cycle after the 4th strobe; cleared the next cycle.
- "A" then word gap: key 1,0,1,1,1,0,0,0 → 0x41. Four further 0 strobes (7 total) → 0x20. Further zeros → nothing more.
- Digits: five 3-unit marks with 1-unit gaps, then 3 zeros → 0x30. Five dots → 0x35. "Q" (--.-) → 0x51.
- Errors: key 1,1,0,0,0 → `err` pulse, `out_valid` stays 0. Six dots then 3 zeros → `err`. Code ..-- → `err`.
- Backpressure: `out_ready`=0; send E then T → `ascii_out` stays 0x45 and `ovf` pulses at T's decode. Raise `out_ready` in the same cycle as a third character's load → new char loaded, no `ovf`.
- Reset: deassert `rst_n` mid-dash with `out_valid`=1 → all outputs 0 immediately. After release, "T" (key 1,1,1,0,0,0) → 0x54.
